// File: rtl/inst_fetcher_pkg.sv
// Shared types and helpers for the instruction fetcher and its I-cache.
package inst_fetcher_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } fetch_state_e;

  // One instruction-queue entry as pushed by the fetcher.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } iq_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped I-cache, one word per line: combinational lookup, synchronous fill,
// async clear of the valid bits.
module inst_fetcher_icache
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned LINES = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:2] i_lookup_word,
  output logic              o_hit_c,
  output logic [INST_W-1:0] o_data_c,
  input  logic              i_fill_we,
  input  logic [ADDR_W-1:2] i_fill_word,
  input  logic [INST_W-1:0] i_fill_data
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_data [LINES];
  logic [LINES-1:0]  r_valid;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [TAG_W-1:0]  w_fill_tag;

  assign w_lk_idx   = i_lookup_word[IDX_W+1:2];
  assign w_lk_tag   = i_lookup_word[ADDR_W-1:IDX_W+2];
  assign w_fill_idx = i_fill_word[IDX_W+1:2];
  assign w_fill_tag = i_fill_word[ADDR_W-1:IDX_W+2];

  assign o_hit_c  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_data_c = r_data[w_lk_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_fill_we) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_fill_we) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_fill_data;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: fetch PC, I-cache lookup, miss handshake with the memory
// controller and registered push into the instruction queue.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 32,
  parameter int unsigned IDX_W        = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic [ADDR_W-1:0] clear_pc,
  input  logic              iq_full,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [INST_W-1:0] mem_data
);

  fetch_state_e      r_state,      w_state_nx;
  logic [ADDR_W-1:0] r_fetch_pc,   w_fetch_pc_nx;
  iq_entry_t         r_out,        w_out_nx;
  logic              r_inst_valid, w_inst_valid_nx;
  logic              r_mem_req,    w_mem_req_nx;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
  logic              w_fill_we;
  logic              w_hit;
  logic [INST_W-1:0] w_hit_data;

  inst_fetcher_icache #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W)
  ) u_icache (
    .i_clk         (clk_in),
    .i_rst         (rst_in),
    .i_lookup_word (r_fetch_pc[ADDR_W-1:2]),
    .o_hit_c       (w_hit),
    .o_data_c      (w_hit_data),
    .i_fill_we     (w_fill_we && rdy_in),
    .i_fill_word   (r_mem_addr[ADDR_W-1:2]),
    .i_fill_data   (mem_data)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_fetch_pc   <= word_align(RESET_PC);
      r_out        <= '0;
      r_inst_valid <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else if (rdy_in) begin
      r_state      <= w_state_nx;
      r_fetch_pc   <= w_fetch_pc_nx;
      r_out        <= w_out_nx;
      r_inst_valid <= w_inst_valid_nx;
      r_mem_req    <= w_mem_req_nx;
      r_mem_addr   <= w_mem_addr_nx;
    end
  end

  // Next-state logic; clear outranks hit, miss and mem_done.
  always_comb begin
    w_state_nx      = r_state;
    w_fetch_pc_nx   = r_fetch_pc;
    w_out_nx        = r_out;
    w_inst_valid_nx = 1'b0;
    w_mem_req_nx    = r_mem_req;
    w_mem_addr_nx   = r_mem_addr;
    w_fill_we       = 1'b0;

    case (r_state)
      IDLE: begin
        if (clear) begin
          w_fetch_pc_nx = word_align(clear_pc);
        end else if (!iq_full) begin
          if (w_hit) begin
            w_inst_valid_nx = 1'b1;
            w_out_nx.inst   = w_hit_data;
            w_out_nx.pc     = r_fetch_pc;
            w_fetch_pc_nx   = r_fetch_pc + PC_STEP;
          end else begin
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = r_fetch_pc;
            w_state_nx    = WAIT_MEM;
          end
        end
      end

      WAIT_MEM: begin
        // A returning word is cached even when the request is being aborted.
        w_fill_we = mem_done;
        if (clear) begin
          w_mem_req_nx  = 1'b0;
          w_fetch_pc_nx = word_align(clear_pc);
          w_state_nx    = IDLE;
        end else if (mem_done) begin
          w_inst_valid_nx = 1'b1;
          w_out_nx.inst   = mem_data;
          w_out_nx.pc     = r_mem_addr;
          w_fetch_pc_nx   = r_mem_addr + PC_STEP;
          w_mem_req_nx    = 1'b0;
          w_state_nx      = IDLE;
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  assign inst_valid = r_inst_valid;
  assign inst       = r_out.inst;
  assign pc         = r_out.pc;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: memory responder, push/request recorders and a
// scoreboard of expected queue pushes and memory addresses.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic [31:0] clear_pc;
  logic        iq_full;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] obs_pc_q[$];
  logic [31:0] obs_inst_q[$];
  logic [31:0] obs_addr_q[$];
  int rd_push = 0;
  int rd_addr = 0;

  int resp_busy = 0;
  int resp_cnt  = 0;

  inst_fetcher #(
    .RESET_PC     (32'h0),
    .ICACHE_LINES (32),
    .IDX_W        (5)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .clear_pc   (clear_pc),
    .iq_full    (iq_full),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_data   (mem_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'(a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Records every queue push.
  always @(negedge clk_in) begin
    if (inst_valid === 1'b1) begin
      obs_pc_q.push_back(pc);
      obs_inst_q.push_back(inst);
    end
  end

  // Memory controller model: answers each request 3 enabled cycles after seeing it.
  always @(posedge clk_in) begin
    if (rst_in) begin
      resp_busy <= 0;
      resp_cnt  <= 0;
      mem_done  <= 1'b0;
      mem_data  <= 32'h0;
    end else if (rdy_in) begin
      mem_done <= 1'b0;
      if (mem_done) begin
        resp_busy <= 0;
      end else if (resp_busy != 0) begin
        if (!mem_req) begin
          resp_busy <= 0;
        end else if (resp_cnt == 1) begin
          mem_done  <= 1'b1;
          mem_data  <= mem_word(mem_addr);
          resp_busy <= 0;
        end else begin
          resp_cnt <= resp_cnt - 1;
        end
      end else if (mem_req) begin
        obs_addr_q.push_back(mem_addr);
        resp_busy <= 1;
        resp_cnt  <= 3;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input logic [31:0] a);
    exp_pc_q.push_back(a);
    exp_inst_q.push_back(mem_word(a));
  endtask

  task automatic drain(input string tag);
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    #1;
    while (exp_pc_q.size() > 0) begin
      e_pc   = exp_pc_q.pop_front();
      e_inst = exp_inst_q.pop_front();
      chk({tag, "_push_seen"}, 32'(rd_push < obs_pc_q.size()), 32'd1);
      if (rd_push < obs_pc_q.size()) begin
        chk({tag, "_push_pc"}, obs_pc_q[rd_push], e_pc);
        chk({tag, "_push_inst"}, obs_inst_q[rd_push], e_inst);
        rd_push++;
      end
    end
    chk({tag, "_extra_push"}, 32'(obs_pc_q.size() - rd_push), 32'd0);
    while (exp_addr_q.size() > 0) begin
      e_addr = exp_addr_q.pop_front();
      chk({tag, "_req_seen"}, 32'(rd_addr < obs_addr_q.size()), 32'd1);
      if (rd_addr < obs_addr_q.size()) begin
        chk({tag, "_req_addr"}, obs_addr_q[rd_addr], e_addr);
        rd_addr++;
      end
    end
    chk({tag, "_extra_req"}, 32'(obs_addr_q.size() - rd_addr), 32'd0);
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] want, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (inst_valid === 1'b1 && pc === want) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_mem_req(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (mem_req === 1'b1) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_mem_done(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (mem_done === 1'b1) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    rst_in   = 1'b1;
    rdy_in   = 1'b1;
    clear    = 1'b0;
    clear_pc = 32'h0;
    iq_full  = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);

    // Reset state
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);

    // Cold cache: three misses in order
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    expect_push(32'h0);
    expect_push(32'h4);
    expect_push(32'h8);
    rst_in = 1'b0;
    wait_pc("t1_reach_pc8", 32'h8, 100);
    clear    = 1'b1;
    clear_pc = 32'h0;
    @(negedge clk_in);
    clear = 1'b0;
    chk("t1_no_push_after_clear", 32'(inst_valid), 32'd0);
    drain("t1");

    // Second pass hits back to back
    expect_push(32'h0);
    expect_push(32'h4);
    expect_push(32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("t2_hit_valid", 32'(inst_valid), 32'd1);
      chk("t2_hit_pc", pc, 32'(i * 4));
      chk("t2_no_mem_req", 32'(mem_req), 32'd0);
    end
    clear    = 1'b1;
    clear_pc = 32'h0;
    @(negedge clk_in);
    clear = 1'b0;
    chk("t2_no_push_after_clear", 32'(inst_valid), 32'd0);
    drain("t2");

    // iq_full stalls a hit stream for 5 cycles
    expect_push(32'h0);
    expect_push(32'h4);
    expect_push(32'h8);
    @(negedge clk_in);
    chk("t3_first_valid", 32'(inst_valid), 32'd1);
    chk("t3_first_pc", pc, 32'h0);
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("t3_stalled", 32'(inst_valid), 32'd0);
    end
    iq_full = 1'b0;
    @(negedge clk_in);
    chk("t3_resume_valid", 32'(inst_valid), 32'd1);
    chk("t3_resume_pc", pc, 32'h4);
    @(negedge clk_in);
    chk("t3_next_valid", 32'(inst_valid), 32'd1);
    chk("t3_next_pc", pc, 32'h8);
    clear    = 1'b1;
    clear_pc = 32'h43;
    @(negedge clk_in);
    clear = 1'b0;
    chk("t3_no_push_after_clear", 32'(inst_valid), 32'd0);
    drain("t3");

    // clear coincides with mem_done for 0x40: filled but not pushed
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h100);
    expect_push(32'h100);
    expect_push(32'h40);
    wait_mem_done("t4_done_0x40", 50);
    chk("t4_mem_addr", mem_addr, 32'h40);
    clear    = 1'b1;
    clear_pc = 32'h100;
    @(negedge clk_in);
    clear = 1'b0;
    chk("t4_no_push_0x40", 32'(inst_valid), 32'd0);
    chk("t4_req_dropped", 32'(mem_req), 32'd0);
    wait_pc("t4_reach_0x100", 32'h100, 50);
    clear    = 1'b1;
    clear_pc = 32'h40;
    @(negedge clk_in);
    clear = 1'b0;
    chk("t4_no_push_after_clear", 32'(inst_valid), 32'd0);
    @(negedge clk_in);
    chk("t4_hit_valid", 32'(inst_valid), 32'd1);
    chk("t4_hit_pc", pc, 32'h40);
    chk("t4_hit_no_req", 32'(mem_req), 32'd0);
    drain("t4");

    // rdy_in low mid-miss freezes everything, even against clear
    exp_addr_q.push_back(32'h44);
    expect_push(32'h44);
    wait_mem_req("t5_req_0x44", 20);
    rdy_in   = 1'b0;
    clear    = 1'b1;
    clear_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("t5_frozen_req", 32'(mem_req), 32'd1);
      chk("t5_frozen_addr", mem_addr, 32'h44);
      chk("t5_frozen_valid", 32'(inst_valid), 32'd0);
    end
    rdy_in = 1'b1;
    clear  = 1'b0;
    wait_pc("t5_reach_0x44", 32'h44, 50);
    drain("t5");

    // Async reset in WAIT_MEM: outputs drop at once, cache comes back cold
    wait_mem_req("t6_req_0x48", 20);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t6_async_req", 32'(mem_req), 32'd0);
    chk("t6_async_valid", 32'(inst_valid), 32'd0);
    chk("t6_async_addr", mem_addr, 32'h0);
    @(negedge clk_in);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    expect_push(32'h0);
    expect_push(32'h4);
    rst_in = 1'b0;
    wait_pc("t6_reach_pc4", 32'h4, 100);
    iq_full = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("t6_held_no_req", 32'(mem_req), 32'd0);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
